fmul_param_pipe: RTL and testbench
==================================

FMUL_PARAM_PIPE -- requirements
Module: fmul_param_pipe

Interface
REQ-001 Parameter EXP_W, default 11: exponent field width.
REQ-002 Parameter FRACT_W, default 60: stored fraction width; word width W = 1+EXP_W+FRACT_W (default 72).
REQ-003 Parameter PIPE_DEPTH, default 2: latency in cycles, legal range 2..6; elaboration error outside the range.
REQ-004 iCLOCK  in  1  the block's one clock; all state changes on its rising edge.
REQ-005 inRESET  in  1  reset, asynchronous and active-low.
REQ-006 iRESET_SYNC  in  1  synchronous clear, active-high.
REQ-007 iDATA_REQ  in  1  input operands valid.
REQ-008 oDATA_BUSY  out  1  block cannot accept; input is taken only when iDATA_REQ && !oDATA_BUSY.
REQ-009 iDATA_A, iDATA_B  in  W  packed operands {sign, exp, fract}.
REQ-010 oDATA_VALID  out  1  result valid.
REQ-011 iDATA_BUSY  in  1  downstream stall.
REQ-012 oDATA_RESULT  out  W  packed, normalised, rounded product.
REQ-013 oDATA_FLAGS  out  5  {invalid, overflow, underflow, inexact, zero}.

Function
REQ-014 Pipeline of PIPE_DEPTH stages; each stage has a valid bit and advances when its own valid is 0 or the next stage accepts; last stage accepts when !iDATA_BUSY.
REQ-015 oDATA_BUSY = stage-0 valid && stage-0 cannot advance; bubbles collapse, so a full pipe with iDATA_BUSY=0 gives one result per cycle.
REQ-016 Latency from an accepted input to oDATA_VALID = exactly PIPE_DEPTH cycles with no stall; results leave in input order; no data is lost or duplicated under any stall pattern.
REQ-017 While oDATA_VALID && iDATA_BUSY, oDATA_RESULT and oDATA_FLAGS hold stable.
REQ-018 Stage 0: sign = sA^sB; unbiased exponent sum eA+eB-BIAS, BIAS = 2^(EXP_W-1)-1, in EXP_W+2-bit signed arithmetic; significand product (FRACT_W+1)x(FRACT_W+1) with the hidden bit = (exp != 0); operand class decode (zero, inf, NaN).
REQ-019 Stages 1..PIPE_DEPTH-2: pass-through retiming registers.
REQ-020 Final stage: if the product MSB is set, shift right 1 and increment the exponent; round-to-nearest-even to FRACT_W bits using guard and sticky; if the rounding carry overflows the significand, renormalise and increment the exponent again.
REQ-021 Exponent >= 2^EXP_W-1 after rounding: result is signed infinity; overflow=1, inexact=1.
REQ-022 Exponent <= 0: flush to signed zero; underflow=1, inexact=1, zero=1; denormal inputs are treated as zero (flush-to-zero on input).
REQ-023 Any NaN input, or inf x zero: canonical quiet NaN {0, all-ones exp, MSB fract=1, rest 0}; invalid=1.
REQ-024 inf x finite non-zero: signed infinity, no flags; zero x finite: signed zero, zero=1.
REQ-025 inexact=1 whenever any discarded guard/sticky bit was non-zero.
REQ-026 Reset or iRESET_SYNC mid-operation discards all in-flight operands; no partial result is emitted.

Reset
REQ-027 On inRESET low, all valid bits go to 0 asynchronously; oDATA_VALID=0, oDATA_BUSY=0, oDATA_RESULT=0, oDATA_FLAGS=0.
REQ-028 iRESET_SYNC=1 applies the same values at the next edge and takes priority over all handshakes.
REQ-029 Data registers are cleared with the valid bits; accepting input resumes the first cycle after reset is released.

Structure
REQ-030 A shared package fmul_pkg holds the flag-index constants, the canonical-NaN builder function, and the operand-class enum {ZERO, NORMAL, INF, NAN}.
REQ-031 One sub-module, fmul_pipe_stage (parametrised width, valid/busy register with enable), is instantiated PIPE_DEPTH times.
REQ-032 The multiplier is a plain * operator with a vendor DSP attribute; there is no hand-built array.

Verification (EXP_W=8, FRACT_W=23, PIPE_DEPTH=3 unless noted)
REQ-033 0x3FC00000 x 0x40000000 -> 0x40400000, flags 0, oDATA_VALID exactly 3 cycles after acceptance.
REQ-034 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact=1; 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1.
REQ-035 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow=1, inexact=1; 0x00800000 x 0x00800000 -> 0x00000000, underflow=1, zero=1.
REQ-036 20 back-to-back inputs with iDATA_BUSY toggled pseudo-randomly -> 20 results in order, output stable during stalls, oDATA_BUSY only when the pipe is full and stalled.
REQ-037 inRESET asserted with 3 operations in flight -> all outputs 0 immediately, and no stale result appears after release.
REQ-038 Default parameters (72-bit) with PIPE_DEPTH=2 and 6: 1.0 x -2.0 -> -2.0 at the matching latency.

Source files
------------

// File: rtl/fmul_pkg.sv
// ---------------------------------------------------------------------------
// fmul_pkg
// Shared definitions for the parametrised pipelined floating-point multiplier:
//   - flag bit positions inside the 5-bit flag word
//     {invalid, overflow, underflow, inexact, zero}
//   - operand class enum and helpers to decode / combine operand classes
//   - canonical quiet-NaN builder, usable for any exponent/fraction width
// ---------------------------------------------------------------------------
package fmul_pkg;

    localparam int FLAG_ZERO      = 0;
    localparam int FLAG_INEXACT   = 1;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_W         = 5;

    // Widest word the NaN builder can produce; callers size-cast down.
    localparam int NAN_MAX_W = 256;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } op_class_t;

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    // Bits fract_w-1 .. fract_w+exp_w-1 are ones, everything else zero.
    function automatic logic [NAN_MAX_W-1:0] canon_nan(input int exp_w, input int fract_w);
        logic [NAN_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < NAN_MAX_W; i++) begin
            if ((i >= fract_w - 1) && (i < fract_w + exp_w)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Denormals (exponent zero, fraction non-zero) are flushed to ZERO.
    function automatic op_class_t classify(input logic exp_zero, input logic exp_ones,
                                           input logic fract_zero);
        if (exp_zero) begin
            return ZERO;
        end else if (exp_ones) begin
            return fract_zero ? INF : NAN;
        end
        return NORMAL;
    endfunction

    // Class of the product given the two operand classes.
    function automatic op_class_t combine_class(input op_class_t a, input op_class_t b);
        if ((a == NAN) || (b == NAN) ||
            ((a == INF) && (b == ZERO)) || ((a == ZERO) && (b == INF))) begin
            return NAN;
        end else if ((a == INF) || (b == INF)) begin
            return INF;
        end else if ((a == ZERO) || (b == ZERO)) begin
            return ZERO;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/fmul_pipe_stage.sv
// ---------------------------------------------------------------------------
// fmul_pipe_stage
// One elastic pipeline register: a valid bit plus a WIDTH-bit payload.
// The stage loads when it is empty or when the next stage accepts, so
// bubbles collapse and a stalled output holds its contents.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_srst           synchronous clear (wins over the load enable)
//   i_valid, i_data  upstream valid / payload
//   i_next_ready     downstream stage accepts this cycle
//   o_ready          this stage accepts this cycle
//   o_valid, o_data  registered valid / payload
// ---------------------------------------------------------------------------
module fmul_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_srst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_next_ready,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_ready = !r_valid || i_next_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_srst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            // Payload only changes on a real load so the last result stays put
            // when a bubble moves through.
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/fmul_param_pipe.sv
// ---------------------------------------------------------------------------
// fmul_param_pipe
// Pipelined floating-point multiplier, PIPE_DEPTH cycles of latency,
// round-to-nearest-even, flush-to-zero on denormal inputs and outputs.
//
// Stage 0 registers the sign, the unbiased exponent sum, the full
// significand product and the result class. Stages 1..PIPE_DEPTH-2 retime
// that payload. The last stage registers the normalised, rounded word and
// its flags.
//
// Ports (W = 1+EXP_W+FRACT_W)
//   iCLOCK        clock
//   inRESET       asynchronous active-low reset
//   iRESET_SYNC   synchronous clear, overrides all handshakes
//   iDATA_REQ     operands valid; taken when iDATA_REQ && !oDATA_BUSY
//   oDATA_BUSY    stage 0 is full and cannot advance
//   iDATA_A/B     packed operands {sign, exp, fract}
//   oDATA_VALID   result valid
//   iDATA_BUSY    downstream stall; result and flags hold while set
//   oDATA_RESULT  packed product
//   oDATA_FLAGS   {invalid, overflow, underflow, inexact, zero}
// ---------------------------------------------------------------------------
module fmul_param_pipe
    import fmul_pkg::*;
#(
    parameter int EXP_W      = 11,
    parameter int FRACT_W    = 60,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iRESET_SYNC,
    input  logic                     iDATA_REQ,
    output logic                     oDATA_BUSY,
    input  logic [EXP_W+FRACT_W:0]   iDATA_A,
    input  logic [EXP_W+FRACT_W:0]   iDATA_B,
    output logic                     oDATA_VALID,
    input  logic                     iDATA_BUSY,
    output logic [EXP_W+FRACT_W:0]   oDATA_RESULT,
    output logic [FLAG_W-1:0]        oDATA_FLAGS
);

    localparam int W   = 1 + EXP_W + FRACT_W;
    localparam int PW  = 2 * FRACT_W + 2;        // significand product width
    localparam int EW  = EXP_W + 2;              // signed working exponent
    localparam int P0W = 2 + 1 + EW + PW;        // {class, sign, exp, product}
    localparam int RW  = FLAG_W + W;             // {flags, result}

    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);

    generate
        if ((PIPE_DEPTH < 2) || (PIPE_DEPTH > 6)) begin : g_bad_depth
            $error("fmul_param_pipe: PIPE_DEPTH must be in 2..6");
        end
    endgenerate

    // ---------------- stage 0: decode, exponent sum, multiply --------------
    logic               w_a_sign, w_b_sign;
    logic [EXP_W-1:0]   w_a_exp, w_b_exp;
    logic [FRACT_W-1:0] w_a_fract, w_b_fract;
    op_class_t          w_a_cls, w_b_cls, w_s0_cls;
    logic signed [EW-1:0] w_s0_exp;
    (* use_dsp = "yes" *) logic [PW-1:0] w_s0_prod;
    logic [P0W-1:0]     w_s0_payload;

    assign {w_a_sign, w_a_exp, w_a_fract} = iDATA_A;
    assign {w_b_sign, w_b_exp, w_b_fract} = iDATA_B;

    assign w_a_cls  = classify(w_a_exp == '0, &w_a_exp, w_a_fract == '0);
    assign w_b_cls  = classify(w_b_exp == '0, &w_b_exp, w_b_fract == '0);
    assign w_s0_cls = combine_class(w_a_cls, w_b_cls);

    assign w_s0_exp = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS;

    // Hidden bit is 1 only for non-zero exponents.
    assign w_s0_prod = PW'({(w_a_exp != '0), w_a_fract}) * PW'({(w_b_exp != '0), w_b_fract});

    assign w_s0_payload = {w_s0_cls, w_a_sign ^ w_b_sign, w_s0_exp, w_s0_prod};

    // ---------------- pipeline registers ----------------------------------
    logic           w_stg_valid [PIPE_DEPTH];
    logic           w_stg_ready [PIPE_DEPTH];
    logic [P0W-1:0] w_stg_data  [PIPE_DEPTH-1];
    logic [RW-1:0]  w_out_data;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH - 1; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                fmul_pipe_stage #(.WIDTH(P0W)) u_stage (
                    .i_clk        (iCLOCK),
                    .i_rst_n      (inRESET),
                    .i_srst       (iRESET_SYNC),
                    .i_valid      (iDATA_REQ),
                    .i_data       (w_s0_payload),
                    .i_next_ready (w_stg_ready[gi+1]),
                    .o_ready      (w_stg_ready[gi]),
                    .o_valid      (w_stg_valid[gi]),
                    .o_data       (w_stg_data[gi])
                );
            end else begin : g_mid
                fmul_pipe_stage #(.WIDTH(P0W)) u_stage (
                    .i_clk        (iCLOCK),
                    .i_rst_n      (inRESET),
                    .i_srst       (iRESET_SYNC),
                    .i_valid      (w_stg_valid[gi-1]),
                    .i_data       (w_stg_data[gi-1]),
                    .i_next_ready (w_stg_ready[gi+1]),
                    .o_ready      (w_stg_ready[gi]),
                    .o_valid      (w_stg_valid[gi]),
                    .o_data       (w_stg_data[gi])
                );
            end
        end
    endgenerate

    // ---------------- final stage: normalise, round, classify -------------
    op_class_t            w_f_cls;
    logic                 w_f_sign;
    logic signed [EW-1:0] w_f_exp;
    logic [PW-1:0]        w_f_prod;

    assign w_f_cls  = op_class_t'(w_stg_data[PIPE_DEPTH-2][P0W-1 -: 2]);
    assign w_f_sign = w_stg_data[PIPE_DEPTH-2][PW+EW];
    assign w_f_exp  = $signed(w_stg_data[PIPE_DEPTH-2][PW+EW-1:PW]);
    assign w_f_prod = w_stg_data[PIPE_DEPTH-2][PW-1:0];

    logic                 w_msb;
    logic [PW-1:0]        w_norm;
    logic signed [EW-1:0] w_exp_n, w_exp_r;
    logic [FRACT_W:0]     w_kept;
    logic                 w_guard, w_sticky;
    logic [FRACT_W+1:0]   w_sum;
    logic [FRACT_W-1:0]   w_fract_r;
    logic [W-1:0]         w_f_result;
    logic [FLAG_W-1:0]    w_f_flags;

    always_comb begin
        w_f_result = '0;
        w_f_flags  = '0;

        // Product of two [1,2) significands lies in [1,4). Align so the
        // leading one always sits at bit PW-1; a right shift of the value is
        // the same as keeping P as-is with the exponent bumped, and the bit it
        // would drop stays inside the sticky field.
        w_msb   = w_f_prod[PW-1];
        w_norm  = w_msb ? w_f_prod : {w_f_prod[PW-2:0], 1'b0};
        w_exp_n = w_msb ? (w_f_exp + EXP_ONE) : w_f_exp;

        w_kept   = w_norm[PW-1:FRACT_W+1];
        w_guard  = w_norm[FRACT_W];
        w_sticky = |w_norm[FRACT_W-1:0];

        // Round half to even.
        w_sum = {1'b0, w_kept} + (FRACT_W+2)'(w_guard & (w_sticky | w_kept[0]));

        // Carry out of the rounding add means the significand became 2.0.
        if (w_sum[FRACT_W+1]) begin
            w_exp_r   = w_exp_n + EXP_ONE;
            w_fract_r = w_sum[FRACT_W:1];
        end else begin
            w_exp_r   = w_exp_n;
            w_fract_r = w_sum[FRACT_W-1:0];
        end

        case (w_f_cls)
            NAN: begin
                w_f_result              = W'(canon_nan(EXP_W, FRACT_W));
                w_f_flags[FLAG_INVALID] = 1'b1;
            end
            INF: begin
                w_f_result = {w_f_sign, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
            end
            ZERO: begin
                w_f_result           = {w_f_sign, {(W-1){1'b0}}};
                w_f_flags[FLAG_ZERO] = 1'b1;
            end
            default: begin
                if (w_exp_r >= EXP_MAX) begin
                    w_f_result                = {w_f_sign, {EXP_W{1'b1}}, {FRACT_W{1'b0}}};
                    w_f_flags[FLAG_OVERFLOW]  = 1'b1;
                    w_f_flags[FLAG_INEXACT]   = 1'b1;
                end else if (w_exp_r <= EXP_ZERO) begin
                    w_f_result                = {w_f_sign, {(W-1){1'b0}}};
                    w_f_flags[FLAG_UNDERFLOW] = 1'b1;
                    w_f_flags[FLAG_INEXACT]   = 1'b1;
                    w_f_flags[FLAG_ZERO]      = 1'b1;
                end else begin
                    w_f_result              = {w_f_sign, w_exp_r[EXP_W-1:0], w_fract_r};
                    w_f_flags[FLAG_INEXACT] = w_guard | w_sticky;
                end
            end
        endcase
    end

    fmul_pipe_stage #(.WIDTH(RW)) u_stage_out (
        .i_clk        (iCLOCK),
        .i_rst_n      (inRESET),
        .i_srst       (iRESET_SYNC),
        .i_valid      (w_stg_valid[PIPE_DEPTH-2]),
        .i_data       ({w_f_flags, w_f_result}),
        .i_next_ready (!iDATA_BUSY),
        .o_ready      (w_stg_ready[PIPE_DEPTH-1]),
        .o_valid      (w_stg_valid[PIPE_DEPTH-1]),
        .o_data       (w_out_data)
    );

    assign oDATA_VALID  = w_stg_valid[PIPE_DEPTH-1];
    assign oDATA_BUSY   = !w_stg_ready[0];
    assign oDATA_RESULT = w_out_data[W-1:0];
    assign oDATA_FLAGS  = w_out_data[RW-1:W];

endmodule

// File: tb/tb_fmul_param_pipe.sv
// ---------------------------------------------------------------------------
// tb_fmul_param_pipe
// Single-precision instance (EXP_W=8, FRACT_W=23, PIPE_DEPTH=3) exercised
// with directed vectors and random streams against an integer-arithmetic
// reference model; two default-width instances (PIPE_DEPTH 2 and 6) check
// latency for a wide operand.
// ---------------------------------------------------------------------------
module tb_fmul_param_pipe;

    localparam int D = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, srst;
    logic        req, dbusy;
    logic [31:0] a, b;
    logic        o_busy, o_valid;
    logic [31:0] o_res;
    logic [4:0]  o_flags;

    logic        wreq, wbusy;
    logic [71:0] wa, wb;
    logic        w2_busy, w2_valid, w6_busy, w6_valid;
    logic [71:0] w2_res, w6_res;
    logic [4:0]  w2_flags, w6_flags;

    fmul_param_pipe #(.EXP_W(8), .FRACT_W(23), .PIPE_DEPTH(D)) dut (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(srst),
        .iDATA_REQ(req), .oDATA_BUSY(o_busy), .iDATA_A(a), .iDATA_B(b),
        .oDATA_VALID(o_valid), .iDATA_BUSY(dbusy),
        .oDATA_RESULT(o_res), .oDATA_FLAGS(o_flags)
    );

    fmul_param_pipe #(.PIPE_DEPTH(2)) dut_w2 (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(srst),
        .iDATA_REQ(wreq), .oDATA_BUSY(w2_busy), .iDATA_A(wa), .iDATA_B(wb),
        .oDATA_VALID(w2_valid), .iDATA_BUSY(wbusy),
        .oDATA_RESULT(w2_res), .oDATA_FLAGS(w2_flags)
    );

    fmul_param_pipe #(.PIPE_DEPTH(6)) dut_w6 (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(srst),
        .iDATA_REQ(wreq), .oDATA_BUSY(w6_busy), .iDATA_A(wa), .iDATA_B(wb),
        .oDATA_VALID(w6_valid), .iDATA_BUSY(wbusy),
        .oDATA_RESULT(w6_res), .oDATA_FLAGS(w6_flags)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] r;
        logic [4:0]  f;
    } exp_t;

    exp_t sb[$];

    // Reference: exact integer significand product, rounded by remainder
    // comparison against one half ulp.
    function automatic exp_t ref_mul(input logic [31:0] x, input logic [31:0] y);
        exp_t res;
        logic s;
        int ex, ey, e, sh;
        logic [22:0] fx, fy;
        bit zx, zy, ix, iy, nx, ny, inex;
        longint unsigned p, qv, rem, half;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = x[22:0];
        fy = y[22:0];
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (fx == 0);
        iy = (ey == 255) && (fy == 0);
        nx = (ex == 255) && (fx != 0);
        ny = (ey == 255) && (fy != 0);
        if (nx || ny || (ix && zy) || (iy && zx)) begin
            res.r = 32'h7FC00000;
            res.f = 5'b10000;
        end else if (ix || iy) begin
            res.r = {s, 8'hFF, 23'h0};
            res.f = 5'b00000;
        end else if (zx || zy) begin
            res.r = {s, 31'h0};
            res.f = 5'b00001;
        end else begin
            p = 64'({1'b1, fx}) * 64'({1'b1, fy});
            e = ex + ey - 127;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end else begin
                sh = 23;
            end
            qv   = p >> sh;
            rem  = p - (qv << sh);
            half = 64'd1 << (sh - 1);
            inex = (rem != 0);
            if ((rem > half) || ((rem == half) && qv[0])) qv = qv + 1;
            if (qv == (64'd1 << 24)) begin
                qv = qv >> 1;
                e  = e + 1;
            end
            if (e >= 255) begin
                res.r = {s, 8'hFF, 23'h0};
                res.f = 5'b01010;
            end else if (e <= 0) begin
                res.r = {s, 31'h0};
                res.f = 5'b00111;
            end else begin
                res.r = {s, 8'(e), qv[22:0]};
                res.f = {3'b000, inex, 1'b0};
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] gen_operand();
        logic       s;
        logic [7:0] e;
        logic [22:0] f;
        int k;
        k = int'($urandom_range(0, 15));
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case (k)
            0:       begin e = 8'd0; if ($urandom_range(0, 1) == 0) f = '0; end
            1:       begin e = 8'hFF; f = '0; end
            2:       begin e = 8'hFF; f = f | 23'd1; end
            3:       e = 8'($urandom_range(200, 254));
            4:       e = 8'($urandom_range(1, 40));
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {s, e, f};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; srst = 1'b0; req = 1'b0; dbusy = 1'b0; a = '0; b = '0;
        wreq = 1'b0; wbusy = 1'b0; wa = '0; wb = '0;
        #12;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", o_busy); end
        tests++; if (o_res !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", o_res); end
        tests++; if (o_flags !== 5'h0) begin fails++; $display("FAIL reset_flags got %b want 0", o_flags); end
        tests++; if ((w2_valid | w6_valid) !== 1'b0) begin fails++; $display("FAIL reset_wide_valid got %b%b want 00", w2_valid, w6_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    // One isolated operation on the 32-bit DUT: latency, value, flags, single pulse.
    task automatic single_op(input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] er, input logic [4:0] ef, input string name);
        int lat;
        lat = 0;
        @(negedge clk);
        a = x; b = y; req = 1'b1; dbusy = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (o_valid === 1'b1) begin lat = c; break; end
        end
        tests++; if (lat !== D) begin fails++; $display("FAIL %s latency got %0d want %0d", name, lat, D); end
        tests++; if (o_res !== er) begin fails++; $display("FAIL %s result got %h want %h", name, o_res, er); end
        tests++; if (o_flags !== ef) begin fails++; $display("FAIL %s flags got %b want %b", name, o_flags, ef); end
        $display("[TB] %s: %h x %h -> %h flags %b lat %0d", name, x, y, o_res, o_flags, lat);
        @(posedge clk); #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL %s pulse valid got %b want 0", name, o_valid); end
    endtask

    task automatic test_directed();
        single_op(32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, "mul_1p5_2");
        single_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00010, "mul_inexact");
        single_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000, "inf_x_zero");
        single_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 5'b01010, "overflow");
        single_op(32'h00800000, 32'h00800000, 32'h00000000, 5'b00111, "underflow");
        single_op(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, "neg_inf_x_2");
        single_op(32'hC0000000, 32'h00000000, 32'h80000000, 5'b00001, "neg2_x_zero");
    endtask

    task automatic test_default_params();
        logic [71:0] want;
        int lat2, lat6;
        logic [71:0] r2, r6;
        logic [4:0]  f2, f6;
        want = {1'b1, 11'd1024, 60'd0};
        lat2 = 0; lat6 = 0; r2 = '0; r6 = '0; f2 = '1; f6 = '1;
        @(negedge clk);
        wa = {1'b0, 11'd1023, 60'd0};
        wb = {1'b1, 11'd1024, 60'd0};
        wreq = 1'b1;
        @(posedge clk); #1;
        wreq = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (w2_valid === 1'b1 && lat2 == 0) begin lat2 = c; r2 = w2_res; f2 = w2_flags; end
            if (w6_valid === 1'b1 && lat6 == 0) begin lat6 = c; r6 = w6_res; f6 = w6_flags; end
        end
        tests++; if (lat2 !== 2) begin fails++; $display("FAIL wide_d2 latency got %0d want 2", lat2); end
        tests++; if (lat6 !== 6) begin fails++; $display("FAIL wide_d6 latency got %0d want 6", lat6); end
        tests++; if (r2 !== want) begin fails++; $display("FAIL wide_d2 result got %h want %h", r2, want); end
        tests++; if (r6 !== want) begin fails++; $display("FAIL wide_d6 result got %h want %h", r6, want); end
        tests++; if ((f2 | f6) !== 5'b0) begin fails++; $display("FAIL wide flags got %b/%b want 0", f2, f6); end
        $display("[TB] wide 1.0 x -2.0: d2 %h lat %0d, d6 %h lat %0d", r2, lat2, r6, lat6);
    endtask

    // Random operands into the 32-bit DUT with iDATA_BUSY driven at random.
    task automatic test_stream(input int n, input int stall_pct, input string name);
        int sent, got, cyc, budget;
        bit hold_prev;
        logic [36:0] held;
        exp_t e;
        bit exp_busy;
        sent = 0; got = 0; cyc = 0; budget = n * 50 + 100;
        hold_prev = 1'b0; held = '0;
        sb.delete();
        while ((got < n) && (cyc < budget)) begin
            @(negedge clk);
            cyc++;
            if (hold_prev) begin
                tests++;
                if ({o_res, o_flags} !== held) begin
                    fails++;
                    $display("FAIL %s stall_hold got %h want %h", name, {o_res, o_flags}, held);
                end
            end
            dbusy = (int'($urandom_range(0, 99)) < stall_pct);
            if (sent < n) begin
                a = gen_operand(); b = gen_operand(); req = 1'b1;
            end else begin
                req = 1'b0;
            end
            #1;
            exp_busy = (sb.size() == D) && dbusy;
            tests++;
            if (o_busy !== exp_busy) begin
                fails++;
                $display("FAIL %s busy got %b want %b (in flight %0d)", name, o_busy, exp_busy, sb.size());
            end
            if (o_valid && !dbusy) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL %s spurious result got %h want none", name, o_res);
                end else begin
                    e = sb.pop_front();
                    if ((o_res !== e.r) || (o_flags !== e.f)) begin
                        fails++;
                        $display("FAIL %s result #%0d got %h/%b want %h/%b", name, got, o_res, o_flags, e.r, e.f);
                    end else begin
                        $display("[TB] %s result #%0d %h flags %b", name, got, o_res, o_flags);
                    end
                end
                got++;
            end
            if (req && !o_busy) begin
                sb.push_back(ref_mul(a, b));
                sent++;
            end
            hold_prev = o_valid && dbusy;
            held = {o_res, o_flags};
        end
        req = 1'b0; dbusy = 1'b0;
        tests++;
        if (got != n) begin fails++; $display("FAIL %s timeout got %0d results want %0d", name, got, n); end
        if (stall_pct == 0) begin
            tests++;
            if (cyc > n + D) begin fails++; $display("FAIL %s throughput got %0d cycles want <= %0d", name, cyc, n + D); end
        end
    endtask

    task automatic fill_three(input bit hold_out);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 32'h3FC00000; b = 32'h40000000; req = 1'b1; dbusy = hold_out;
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL %s stale result got valid want none", name); end
    endtask

    task automatic test_sync_reset();
        fill_three(1'b1);
        srst = 1'b1;
        @(posedge clk); #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL srst_valid got %b want 0", o_valid); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL srst_busy got %b want 0", o_busy); end
        tests++; if (o_res !== 32'h0) begin fails++; $display("FAIL srst_result got %h want 0", o_res); end
        tests++; if (o_flags !== 5'h0) begin fails++; $display("FAIL srst_flags got %b want 0", o_flags); end
        @(negedge clk);
        srst = 1'b0; dbusy = 1'b0;
        check_quiet("srst");
        $display("[TB] sync reset with 3 in flight done");
        single_op(32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, "after_srst");
    endtask

    task automatic test_async_reset();
        fill_three(1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got %b want 0", o_valid); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL arst_busy got %b want 0", o_busy); end
        tests++; if (o_res !== 32'h0) begin fails++; $display("FAIL arst_result got %h want 0", o_res); end
        tests++; if (o_flags !== 5'h0) begin fails++; $display("FAIL arst_flags got %b want 0", o_flags); end
        @(negedge clk);
        rst_n = 1'b1; dbusy = 1'b0;
        check_quiet("arst");
        $display("[TB] async reset with 3 in flight done");
        single_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00010, "after_arst");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_default_params();
        test_stream(20, 50, "b2b20");
        test_stream(200, 30, "rand200");
        test_stream(60, 0, "nostall");
        test_sync_reset();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
